// File: rtl/one_wire_read_master.sv
// 1-Wire read master: reset/presence, one command byte, then READ_WORDS
// 16-bit words pushed into the write side of a downstream FIFO.
// Optional build macro: OW_CRC8_EN adds a Dallas CRC-8 over all read bits
// and the crc_ok_o output.
module one_wire_read_master #(
    parameter int         CLKS_PER_US = 50,
    parameter logic [7:0] CMD_BYTE    = 8'hBE,
    parameter int         READ_WORDS  = 4
) (
    input  logic        wr_clk_i,
    input  logic        a_rst_n_i,
    input  logic        start_i,
    input  logic        ow_sense_i,
    output logic        ow_drive_low_o,
    input  logic        full_i,
    input  logic        rst_busy_i,
    output logic [15:0] wdata_o,
    output logic        wr_en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        no_presence_o
`ifdef OW_CRC8_EN
   ,output logic        crc_ok_o
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RST_LOW = 3'd1;
    localparam logic [2:0] S_RST_REL = 3'd2;
    localparam logic [2:0] S_CMD     = 3'd3;
    localparam logic [2:0] S_RD      = 3'd4;
    localparam logic [2:0] S_PUSH    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam int            PW         = (CLKS_PER_US > 2) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRE_MAX    = PW'(CLKS_PER_US - 1);
    localparam logic [7:0]    WORDS_LAST = 8'(READ_WORDS - 1);

    logic [1:0]    sync;
    logic          sense;
    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [PW-1:0] pre;
    logic [8:0]    us;
    logic          tick;
    logic          restart;
    logic [3:0]    bit_cnt;
    logic [7:0]    word_cnt;
    logic [15:0]   shreg;
    logic          present;
    logic          no_pres;
    logic          rst_end;
    logic          slot_end;
    logic          rd_pt;
    logic          push_ok;
`ifdef OW_CRC8_EN
    logic [7:0]    crc;
    logic          crc_ok;
`endif

    assign sense    = sync[1];
    assign tick     = (pre == PRE_MAX);
    // us counts completed microseconds, so "tick && us==N-1" marks the N us point
    assign rst_end  = tick && (us == 9'd479);
    assign slot_end = tick && (us == 9'd69);
    assign rd_pt    = tick && (us == 9'd14);
    assign push_ok  = (state == S_PUSH) && !full_i && !rst_busy_i;
    // every state change and every new slot starts a fresh microsecond count
    assign restart  = (state_next != state) ||
                      (((state == S_CMD) || (state == S_RD)) && slot_end);

    // two-flop synchronizer for the raw bus level
    always_ff @(posedge wr_clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) sync <= 2'b11;
        else            sync <= {sync[0], ow_sense_i};
    end

    // 1 us prescaler and phase timer
    always_ff @(posedge wr_clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            pre <= '0;
            us  <= '0;
        end else if (restart) begin
            pre <= '0;
            us  <= '0;
        end else if (tick) begin
            pre <= '0;
            us  <= us + 9'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start_i)  state_next = S_RST_LOW;
            S_RST_LOW: if (rst_end)  state_next = S_RST_REL;
            S_RST_REL: if (rst_end)  state_next = present ? S_CMD : S_DONE;
            S_CMD:     if (slot_end && bit_cnt == 4'd7)  state_next = S_RD;
            S_RD:      if (slot_end && bit_cnt == 4'd15) state_next = S_PUSH;
            S_PUSH:    if (push_ok)  state_next = (word_cnt == WORDS_LAST) ? S_DONE : S_RD;
            S_DONE:                  state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    // state, counters, presence, word assembly and CRC
    always_ff @(posedge wr_clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
            present  <= 1'b0;
            no_pres  <= 1'b0;
`ifdef OW_CRC8_EN
            crc      <= '0;
            crc_ok   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state == S_IDLE && start_i) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
                present  <= 1'b0;
                no_pres  <= 1'b0;
`ifdef OW_CRC8_EN
                crc      <= '0;
                crc_ok   <= 1'b0;
`endif
            end
            if (state == S_RST_REL && tick && us == 9'd69)
                present <= ~sense;
            if (state == S_RST_REL && rst_end && !present)
                no_pres <= 1'b1;
            if ((state == S_CMD || state == S_RD) && slot_end)
                bit_cnt <= (state_next != state) ? 4'd0 : bit_cnt + 4'd1;
            // first bit received ends up at bit 0
            if (state == S_RD && rd_pt) begin
                shreg <= {sense, shreg[15:1]};
`ifdef OW_CRC8_EN
                crc   <= {1'b0, crc[7:1]} ^ ((crc[0] ^ sense) ? 8'h8C : 8'h00);
`endif
            end
            if (push_ok) begin
                word_cnt <= word_cnt + 8'd1;
`ifdef OW_CRC8_EN
                // CRC already covers the final slave byte when the last word leaves
                if (word_cnt == WORDS_LAST) crc_ok <= (crc == 8'h00);
`endif
            end
        end
    end

    // open-drain drive: reset pulse, write-slot low time, read-slot strobe
    always_comb begin
        ow_drive_low_o = 1'b0;
        case (state)
            S_RST_LOW: ow_drive_low_o = 1'b1;
            S_CMD:     ow_drive_low_o = CMD_BYTE[bit_cnt[2:0]] ? (us < 9'd6) : (us < 9'd60);
            S_RD:      ow_drive_low_o = (us < 9'd6);
            default:   ow_drive_low_o = 1'b0;
        endcase
    end

    assign wdata_o       = shreg;
    assign wr_en_o       = push_ok;
    assign busy_o        = (state != S_IDLE);
    assign done_o        = (state == S_DONE);
    assign no_presence_o = no_pres;
`ifdef OW_CRC8_EN
    assign crc_ok_o      = crc_ok;
`endif

endmodule

// File: tb/tb_one_wire_read_master.sv
// Bench for one_wire_read_master: table of transactions plus a reset-abort
// sequence and a randomized transaction, checked against a slave/FIFO model.
module tb_one_wire_read_master;
    localparam int C  = 4;
    localparam int NW = 2;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        start = 0;
    logic        full = 0;
    logic        rbusy = 0;
    logic        drive, wr_en, busy, done, np, sense, slave_low;
    logic [15:0] wdata;
`ifdef OW_CRC8_EN
    logic        crc_ok;
`endif

    always #5 clk = ~clk;
    assign sense = ~(drive | slave_low);

    one_wire_read_master #(.CLKS_PER_US(C), .CMD_BYTE(8'hBE), .READ_WORDS(NW)) dut (
        .wr_clk_i(clk), .a_rst_n_i(rst_n), .start_i(start), .ow_sense_i(sense),
        .ow_drive_low_o(drive), .full_i(full), .rst_busy_i(rbusy), .wdata_o(wdata),
        .wr_en_o(wr_en), .busy_o(busy), .done_o(done), .no_presence_o(np)
`ifdef OW_CRC8_EN
       ,.crc_ok_o(crc_ok)
`endif
    );

    typedef struct { bit present; logic [15:0] w0; logic [15:0] w1; int stall; } vec_t;

    int          tests = 0, fails = 0;
    int          cyc = 0;
    logic        drv_q = 0;
    int          fall_q[$], rise_q[$], push_t[$], done_t[$];
    logic [15:0] push_d[$];
    int          ev = 0, pull_from = 0, pull_to = 0;
    bit          slave_present = 1;
    logic [15:0] slave_words [NW];

    assign slave_low = (cyc >= pull_from) && (cyc < pull_to);

    // slave model and bus/FIFO-port monitor, all on the falling edge
    always @(negedge clk) begin
        cyc   <= cyc + 1;
        drv_q <= drive;
        if (!rst_n) begin
            ev <= 0; pull_to <= 0;
        end else if (start && !busy) begin
            ev <= 0; pull_to <= 0;
            fall_q.delete(); rise_q.delete(); push_t.delete(); push_d.delete(); done_t.delete();
        end else begin
            if (drive && !drv_q) begin
                automatic int k = ev - 9;
                automatic logic [15:0] w = (k >= 16) ? slave_words[1] : slave_words[0];
                fall_q.push_back(cyc);
                if (ev == 0) begin
                    if (slave_present) begin pull_from <= cyc + 495*C; pull_to <= cyc + 615*C; end
                end else if (k >= 0 && k < 16*NW) begin
                    if (!w[k[3:0]]) begin pull_from <= cyc; pull_to <= cyc + 30*C; end
                end
                ev <= ev + 1;
            end
            if (!drive && drv_q) rise_q.push_back(cyc);
            if (wr_en) begin push_t.push_back(cyc); push_d.push_back(wdata); end
            if (done) done_t.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Dallas CRC-8, LSB first, init 0
    function automatic logic [7:0] crc8(input logic [31:0] bits, input int n);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = c[0] ^ bits[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        logic [7:0] cmd;
        cmd = 8'hBE;
        slave_present = v.present;
        slave_words[0] = v.w0;
        slave_words[1] = v.w1;
        full  = (v.stall == 1);
        rbusy = (v.stall == 2);
        start = 1; step(1); start = 0;
        chk({tag, " drive after start"}, int'(drive), 1);
        if (v.stall != 0) begin
            n = 0;
            while (fall_q.size() < 25 && n < 20000) begin step(1); n++; end
            chk({tag, " reached word0 end"}, int'(fall_q.size() >= 25), 1);
            step(300);
            n = fall_q.size();
            step(1000);
            chk({tag, " no slot during stall"}, fall_q.size(), n);
            chk({tag, " no push during stall"}, push_t.size(), 0);
            full = 0; rbusy = 0; n = cyc;
            step(1);
            chk({tag, " push on release"}, at(push_t, 0), n);
        end
        n = 0;
        while (done_t.size() == 0 && n < 20000) begin step(1); n++; end
        step(5);
        chk({tag, " done count"}, done_t.size(), 1);
        chk({tag, " busy after done"}, int'(busy), 0);
        chk({tag, " reset pulse"}, at(rise_q, 0) - at(fall_q, 0), 480*C);
        chk({tag, " no_presence"}, int'(np), int'(!v.present));
        if (!v.present) begin
            chk({tag, " done after release"}, at(done_t, 0) - at(rise_q, 0), 480*C);
            chk({tag, " push count"}, push_t.size(), 0);
            chk({tag, " fall count"}, fall_q.size(), 1);
        end else begin
            chk({tag, " first slot delay"}, at(fall_q, 1) - at(rise_q, 0), 480*C);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("%s cmd width %0d", tag, i), at(rise_q, i+1) - at(fall_q, i+1),
                    cmd[i] ? 6*C : 60*C);
                chk($sformatf("%s slot spacing %0d", tag, i), at(fall_q, i+2) - at(fall_q, i+1), 70*C);
            end
            chk({tag, " read width"}, at(rise_q, 9) - at(fall_q, 9), 6*C);
            if (v.stall == 0) chk({tag, " push latency"}, at(push_t, 0) - at(fall_q, 24), 70*C);
            chk({tag, " push count"}, push_t.size(), 2);
            chk({tag, " word0"}, (push_d.size() > 0) ? int'(push_d[0]) : -1, int'(v.w0));
            chk({tag, " word1"}, (push_d.size() > 1) ? int'(push_d[1]) : -1, int'(v.w1));
        end
`ifdef OW_CRC8_EN
        chk({tag, " crc_ok"}, int'(crc_ok), int'(v.present && crc8({v.w1, v.w0}, 32) == 8'h00));
`endif
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl[$];
        vec_t rv;
        logic [7:0] cb;
        int n;

        cb = crc8({8'h5A, 16'h3C01}, 24);
        tbl.push_back('{present: 0, w0: 16'h0000, w1: 16'h0000, stall: 0});
        tbl.push_back('{present: 1, w0: 16'hA55A, w1: 16'h1234, stall: 1});
`ifdef OW_CRC8_EN
        tbl.push_back('{present: 1, w0: 16'h3C01, w1: {cb, 8'h5A}, stall: 0});
        tbl.push_back('{present: 1, w0: 16'h3D01, w1: {cb, 8'h5A}, stall: 2});
`endif

        #2 rst_n = 0;
        step(2);
        chk("reset drive", int'(drive), 0);
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset wdata", int'(wdata), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset no_presence", int'(np), 0);
`ifdef OW_CRC8_EN
        chk("reset crc_ok", int'(crc_ok), 0);
`endif
        rst_n = 1;
        step(3);

        for (int i = 0; i < tbl.size(); i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            step(10);
        end

        // abort in the middle of a read slot
        slave_present = 1;
        slave_words[0] = 16'($urandom());
        slave_words[1] = 16'($urandom());
        start = 1; step(1); start = 0;
        n = 0;
        while (fall_q.size() < 12 && n < 20000) begin step(1); n++; end
        step(2);
        chk("abort drive before", int'(drive), 1);
        rst_n = 0; #1;
        chk("abort drive released", int'(drive), 0);
        chk("abort busy", int'(busy), 0);
        step(3);
        rst_n = 1;
        step(3000);
        chk("abort no push", push_t.size(), 0);
        chk("abort no done", done_t.size(), 0);
        chk("abort idle", int'(busy), 0);

        rv.present = 1;
        rv.w0 = 16'($urandom());
        rv.w1 = 16'($urandom());
        rv.stall = int'($urandom_range(0, 2));
        run_txn(rv, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
